// File: rtl/cpu_pkg.sv
// Shared definitions for the sequencer: opcodes, FSM states, ALU selects and
// the control-output bundle.
package cpu_pkg;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        HALT   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_ADD  = 2'd1,
        ALU_AND  = 2'd2,
        ALU_XOR  = 2'd3
    } alu_op_t;

    typedef struct packed {
        logic    ir_load;
        logic    pc_inc;
        logic    write_en;
        logic    skip;
        logic    reg_write;
        logic    alu_to_acc;
        logic    branch;
        logic    halted;
        logic    illegal;
        alu_op_t alu_op;
    } ctrl_t;

    // Control word presented while fetching; also the reset value.
    function automatic ctrl_t fetch_ctrl();
        ctrl_t c;
        c         = '0;
        c.ir_load = 1'b1;
        return c;
    endfunction

    // LDA and STO wait in EXEC for the memory handshake.
    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == OP_LDA) || (op == OP_STO);
    endfunction

endpackage

// File: rtl/op_decode.sv
// Combinational map from the latched opcode and the zero flag to the control
// word driven while the FSM is in EXEC.
module op_decode
    import cpu_pkg::*;
(
    input  logic [2:0] op,
    input  logic       zero,
    output ctrl_t      ctrl
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        ctrl = '0;
        case (op)
            OP_SKZ: begin
                ctrl.skip   = zero;
                ctrl.pc_inc = zero;
            end
            OP_ADD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_to_acc = 1'b1;
                ctrl.alu_op     = ALU_ADD;
            end
            OP_AND: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_to_acc = 1'b1;
                ctrl.alu_op     = ALU_AND;
            end
            OP_XOR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_to_acc = 1'b1;
                ctrl.alu_op     = ALU_XOR;
            end
            OP_LDA: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_PASS;
            end
            OP_STO:  ctrl.write_en = 1'b1;
            OP_JMP:  ctrl.branch   = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/seq_controller.sv
// Fetch/decode/execute sequencer with registered Moore control outputs.
// Define SEQ_CTRL_ILLEGAL_TRAP_EN to halt on opcodes with nonzero upper bits.
module seq_controller
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = 3,
    parameter int ALU_OP_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                zero,
    output logic                ir_load,
    output logic                pc_inc,
    output logic                write_en,
    output logic                skip,
    output logic                reg_write,
    output logic                alu_to_acc,
    output logic                branch,
    output logic                halted,
    output logic                illegal,
    output logic [ALU_OP_W-1:0] alu_op
);

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    ctrl_t               ctrl_q, ctrl_d;
    ctrl_t               exec_ctrl;
    logic                trap;

`ifdef SEQ_CTRL_ILLEGAL_TRAP_EN
    assign trap = |(op_q >> 3);
`else
    logic unused_upper_bits;
    assign unused_upper_bits = |(op_q >> 3);
    assign trap              = 1'b0;
`endif

    op_decode u_op_decode (
        .op   (op_q[2:0]),
        .zero (zero),
        .ctrl (exec_ctrl)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            FETCH: begin
                if (mem_ready) begin
                    op_d    = opcode;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (op_q[2:0] == OP_HLT || trap) state_d = HALT;
                else                             state_d = EXEC;
            end
            EXEC: begin
                if (!is_mem_op(op_q[2:0]) || mem_ready) state_d = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Outputs are decoded from the next state so the registered copy lines up
    // with the state register; op_q is already valid whenever EXEC or HALT is next.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            FETCH:  ctrl_d.ir_load = 1'b1;
            DECODE: ctrl_d.pc_inc  = 1'b1;
            EXEC:   ctrl_d         = exec_ctrl;
            HALT: begin
                ctrl_d.halted  = 1'b1;
                ctrl_d.illegal = trap;
            end
            default: ctrl_d = fetch_ctrl();
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q <= FETCH;
            op_q    <= '0;
            ctrl_q  <= fetch_ctrl();
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign ir_load    = ctrl_q.ir_load;
    assign pc_inc     = ctrl_q.pc_inc;
    assign write_en   = ctrl_q.write_en;
    assign skip       = ctrl_q.skip;
    assign reg_write  = ctrl_q.reg_write;
    assign alu_to_acc = ctrl_q.alu_to_acc;
    assign branch     = ctrl_q.branch;
    assign halted     = ctrl_q.halted;
    assign illegal    = ctrl_q.illegal;
    assign alu_op     = ALU_OP_W'(ctrl_q.alu_op);

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller (OPCODE_W=4); expectations follow
// SEQ_CTRL_ILLEGAL_TRAP_EN when it is defined.
module tb_seq_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       zero = 1'b0;
    logic       ir_load, pc_inc, write_en, skip, reg_write, alu_to_acc;
    logic       branch, halted, illegal;
    logic [1:0] alu_op;

    int total = 0;
    int bad   = 0;

    seq_controller #(.OPCODE_W(4), .ALU_OP_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .zero       (zero),
        .ir_load    (ir_load),
        .pc_inc     (pc_inc),
        .write_en   (write_en),
        .skip       (skip),
        .reg_write  (reg_write),
        .alu_to_acc (alu_to_acc),
        .branch     (branch),
        .halted     (halted),
        .illegal    (illegal),
        .alu_op     (alu_op)
    );

    always #5 clk = ~clk;

    // Packs an expected control word: ir pc we sk rw aa br h il alu.
    function automatic logic [15:0] ev(input bit ir, input bit pc, input bit we, input bit sk,
                                       input bit rw, input bit aa, input bit br, input bit h,
                                       input bit il, input logic [1:0] a);
        return {5'b0, ir, pc, we, sk, rw, aa, br, h, il, a};
    endfunction

    function automatic logic [15:0] obs();
        return {5'b0, ir_load, pc_inc, write_en, skip, reg_write, alu_to_acc,
                branch, halted, illegal, alu_op};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        check({tag, "_rst_out"}, obs(), ev(1,0,0,0,0,0,0,0,0,2'd0));
        check({tag, "_rst_opq"}, {12'b0, dut.op_q}, 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Single-cycle instruction with mem_ready tied high: FETCH, DECODE, EXEC, FETCH.
    task automatic run_simple(input string tag, input logic [3:0] op, input bit z,
                              input logic [15:0] exp_exec);
        do_reset(tag);
        opcode    = op;
        mem_ready = 1'b1;
        zero      = z;
        check({tag, "_fetch"}, obs(), ev(1,0,0,0,0,0,0,0,0,2'd0));
        tick();
        check({tag, "_decode"}, obs(), ev(0,1,0,0,0,0,0,0,0,2'd0));
        opcode = ~op;
        tick();
        check({tag, "_exec"}, obs(), exp_exec);
        zero = ~z;
        tick();
        check({tag, "_refetch"}, obs(), ev(1,0,0,0,0,0,0,0,0,2'd0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        // Single-cycle opcodes, including SKZ with both zero values
        run_simple("add", 4'b0010, 1'b1, ev(0,0,0,0,1,1,0,0,0,2'd1));
        run_simple("and", 4'b0011, 1'b0, ev(0,0,0,0,1,1,0,0,0,2'd2));
        run_simple("xor", 4'b0100, 1'b1, ev(0,0,0,0,1,1,0,0,0,2'd3));
        run_simple("jmp", 4'b0111, 1'b0, ev(0,0,0,0,0,0,1,0,0,2'd0));
        run_simple("skz1", 4'b0001, 1'b1, ev(0,1,0,1,0,0,0,0,0,2'd0));
        run_simple("skz0", 4'b0001, 1'b0, ev(0,0,0,0,0,0,0,0,0,2'd0));

        // STO with four wait cycles: write_en held for five EXEC cycles
        do_reset("sto");
        opcode    = 4'b0110;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("sto_exec%0d", i), obs(), ev(0,0,1,0,0,0,0,0,0,2'd0));
            opcode    = 4'($urandom);
            mem_ready = (i == 4);
            tick();
        end
        check("sto_refetch", obs(), ev(1,0,0,0,0,0,0,0,0,2'd0));

        // HLT: halted from the cycle after DECODE, immune to inputs until reset
        do_reset("hlt");
        opcode    = 4'b0000;
        mem_ready = 1'b1;
        tick();
        check("hlt_decode", obs(), ev(0,1,0,0,0,0,0,0,0,2'd0));
        tick();
        for (int i = 0; i < 20; i++) begin
            check($sformatf("hlt_hold%0d", i), obs(), ev(0,0,0,0,0,0,0,1,0,2'd0));
            opcode    = 4'($urandom);
            mem_ready = 1'($urandom);
            zero      = 1'($urandom);
            tick();
        end
        do_reset("hlt_exit");
        check("hlt_exit_fetch", obs(), ev(1,0,0,0,0,0,0,0,0,2'd0));

        // LDA waiting on memory, then reset asserted mid-EXEC
        do_reset("lda");
        opcode    = 4'b0101;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        check("lda_exec0", obs(), ev(0,0,0,0,1,0,0,0,0,2'd0));
        tick();
        check("lda_exec1", obs(), ev(0,0,0,0,1,0,0,0,0,2'd0));
        #2;
        rst = 1'b1;
        #1;
        check("lda_async_out", obs(), ev(1,0,0,0,0,0,0,0,0,2'd0));
        check("lda_async_opq", {12'b0, dut.op_q}, 16'h0);
        check("lda_async_state", {14'b0, dut.state_q}, 16'h0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        opcode    = 4'b0101;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        check("lda2_exec", obs(), ev(0,0,0,0,1,0,0,0,0,2'd0));
        mem_ready = 1'b1;
        tick();
        check("lda2_refetch", obs(), ev(1,0,0,0,0,0,0,0,0,2'd0));

        // Opcode 1010: illegal trap when enabled, otherwise executes as ADD
`ifdef SEQ_CTRL_ILLEGAL_TRAP_EN
        do_reset("ill");
        opcode    = 4'b1010;
        mem_ready = 1'b1;
        tick();
        check("ill_decode", obs(), ev(0,1,0,0,0,0,0,0,0,2'd0));
        tick();
        check("ill_halt0", obs(), ev(0,0,0,0,0,0,0,1,1,2'd0));
        tick();
        check("ill_halt1", obs(), ev(0,0,0,0,0,0,0,1,1,2'd0));
        do_reset("ill_exit");
`else
        run_simple("ill_as_add", 4'b1010, 1'b0, ev(0,0,0,0,1,1,0,0,0,2'd1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
